uart_rx: RTL
============

// Module: uart_rx
//
// PURPOSE
//   UART receiver: the downstream peer of uart_tx. It deserialises the 8N1 line
//   (uart_txd of uart_tx, or an external pin) into bytes on uart_data_out.
//   Mid-bit sampling uses a CLK_GOAL-cycle bit counter.
//   Sits between the pad/loopback wire and the byte-level consumer, such as a
//   command parser or FIFO.
//
// PARAMETERS
//   CLK_F     50_000_000        system clock frequency, Hz
//   UART_BPS  115200            baud rate, bit/s
//   CLK_GOAL  CLK_F/UART_BPS    clocks per bit (434 at defaults); must be >= 16
//
// PORTS
//   clk             in   1  system clock, rising edge
//   rst_n           in   1  reset: synchronous, active-low
//   uart_rxd        in   1  serial line, asynchronous, idles high
//   uart_data_out   out  8  last good byte, LSB = first data bit; held until next good frame
//   rx_done         out  1  one-cycle pulse: uart_data_out just updated
//   rx_frame_err    out  1  one-cycle pulse: stop bit sampled low
//   rx_busy         out  1  high from start-edge detect until return to IDLE
//
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state=IDLE; all outputs 0.
//   - Shift register and counters 0.
//   - Both synchroniser flops and the edge-history flop are set to 1.
// - Input path: 2-FF synchroniser -> rxd_s. A falling edge is rxd_s=0 while the
//   previous rxd_s=1. Edge detect lags the pin by 3 clk; this lag is tolerated,
//   not compensated.
// - Bit counter clk_cnt counts 0..CLK_GOAL-1 and then wraps.
//   - Sample point: clk_cnt == CLK_GOAL/2 (integer division).
//   - clk_cnt clears on every state change.
// - FSM:
//   - IDLE: rx_busy=0. On a falling edge -> START, rx_busy=1.
//   - START: at the sample point, rxd_s=1 means a false start -> IDLE (no pulse).
//     rxd_s=0 -> DATA, bit_cnt=0.
//   - DATA: at each sample point, shift rxd_s into bit 7 of shreg (LSB first) and
//     increment bit_cnt. After the 8th sample -> STOP (or PARITY if the macro is defined).
//   - STOP: at the sample point, go to IDLE. The matching result pulse fires on the
//     next clk.
//     - rxd_s=1: uart_data_out<=shreg, and rx_done pulses.
//     - rxd_s=0: rx_frame_err pulses; uart_data_out is unchanged.
// - Latency: rx_done rises 1 clk after the mid-stop sample, about 9.5 bit times
//   after the pin's falling edge.
// - Returning to IDLE at mid-stop means a start edge directly after the stop bit
//   (zero idle gap) is caught.
// - rx_done, rx_frame_err and rx_parity_err are mutually exclusive; at most one
//   pulses per frame.
// - Line held low through reset release: this is treated as a start bit and ends
//   in rx_frame_err. The block then stays in IDLE until the line goes high and falls again.
// - Reset mid-frame: the frame is abandoned immediately and no pulse is emitted.
//   The next frame needs a fresh falling edge.
// - Widths: clk_cnt is $clog2(CLK_GOAL) bits; bit_cnt is 4 bits.
//
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - Frame is 8E1.
//   - PARITY state follows DATA and samples the bit at mid-bit, then always goes to STOP.
//   - Extra port: rx_parity_err  out  1, a one-cycle pulse at frame end.
//     It fires when the stop bit is good but ^shreg != the sampled parity bit.
//   - On a parity error: no rx_done, and uart_data_out is unchanged.
//   - A bad stop bit reports rx_frame_err only.
// - Undefined: 8N1; no PARITY state; port rx_parity_err absent.
//
// TESTING (clk period 20 ns, bit = 434 clk = 8680 ns; drive via a uart_tx instance or bench task)
// 1. Reset: rst_n=0 for 2 clk, rxd=1
//    -> uart_data_out=0, rx_done=rx_frame_err=rx_busy=0.
//    Then release with no activity -> all outputs stay 0.
// 2. Loopback of 8'b1010_1100 from uart_tx
//    -> exactly one rx_done pulse, uart_data_out=8'hAC, rx_busy low within 1 clk.
// 3. Back-to-back 8'h6E then 8'hC2, with zero idle between stop and start
//    -> two rx_done pulses 10 bit times apart, data 8'h6E then 8'hC2.
// 4. Glitch: rxd low for 2000 ns (below half a bit), then a frame 8'h55
//    -> no pulse during the glitch, then rx_done with 8'h55.
// 5. Frame 8'h3C with the stop bit forced low
//    -> rx_frame_err pulse, no rx_done, uart_data_out keeps 8'h55.
//    With UART_RX_PARITY_EN: 8'hAC with parity=1 -> rx_parity_err pulse, no rx_done.
// 6. rst_n=0 for 1 clk during data bit 4 of 8'hFF, then a full frame 8'hA5
//    -> no pulse for the aborted frame, then rx_done with 8'hA5.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, falling-edge start detect, mid-bit sampling, 8N1 frames.
// Defining UART_RX_PARITY_EN switches to 8E1 and adds the rx_parity_err pulse output.
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLK_F    = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int CLK_GOAL = CLK_F / UART_BPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data_out,
  output logic       rx_done,
  output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);

  localparam int CW = $clog2(CLK_GOAL);
  localparam logic [CW-1:0] MID  = CW'(CLK_GOAL / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_GOAL - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rxd_m;
  logic            rxd_s;
  logic            rxd_prev;
  logic [CW-1:0]   clk_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            sample;
  logic            bit_end;
  logic            fall;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  assign sample  = (clk_cnt == MID);
  assign bit_end = (clk_cnt == LAST);
  assign fall    = rxd_prev & ~rxd_s;
  assign rx_busy = (state != IDLE);

  // START and DATA hand over at the bit boundary so every state's counter
  // stays aligned to bit edges; STOP alone leaves at its mid-bit sample.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (fall) state_nxt = START;
      START: begin
        if (sample && rxd_s)  state_nxt = IDLE;
        else if (bit_end)     state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == 4'd8) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (sample)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rxd_m         <= 1'b1;
      rxd_s         <= 1'b1;
      rxd_prev      <= 1'b1;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      uart_data_out <= '0;
      rx_done       <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rxd_m        <= uart_rxd;
      rxd_s        <= rxd_m;
      rxd_prev     <= rxd_s;
      state        <= state_nxt;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      if (state_nxt != state || state == IDLE || bit_end) clk_cnt <= '0;
      else                                                clk_cnt <= clk_cnt + CW'(1);

      if (state == START && state_nxt == DATA) bit_cnt <= '0;

      if (state == DATA && sample) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end

`ifdef UART_RX_PARITY_EN
      if (state == PARITY && sample) par_bit <= rxd_s;
`endif

      if (state == STOP && sample) begin
        if (!rxd_s) begin
          rx_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if ((^shreg) != par_bit) begin
          rx_parity_err <= 1'b1;
`endif
        end else begin
          uart_data_out <= shreg;
          rx_done       <= 1'b1;
        end
      end
    end
  end

endmodule
